// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: single-outstanding
// imem requests, 1-entry skid buffer for decode stalls, redirect flush/drain.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        id_valid_d;
  logic [31:0] id_instr_d, id_pc_d, id_pc_plus4_d;
  logic        id_hold, rsp_load, skid_load;

  // Held in reset so a mid-transaction rst never leaves a request dangling.
  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = pc_q;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    rsp_load     = 1'b0;
    skid_load    = 1'b0;
    id_hold      = id_valid && stall;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!id_hold) begin
            rsp_load = 1'b1;
            state_d  = S_REQ;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          skid_load    = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect beats everything; only a still-outstanding request forces a drain.
    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      skid_valid_d = 1'b0;
      case (state_q)
        S_REQ:   state_d = imem_ready  ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid ? S_REQ   : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end

    id_valid_d    = id_valid;
    id_instr_d    = id_instr;
    id_pc_d       = id_pc;
    id_pc_plus4_d = id_pc_plus4;
    if (redirect) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (id_hold) begin
      id_valid_d = 1'b1;
    end else if (rsp_load) begin
      id_valid_d    = 1'b1;
      id_instr_d    = imem_rdata;
      id_pc_d       = req_pc_q;
      id_pc_plus4_d = req_pc_q + 32'd4;
    end else if (skid_load) begin
      id_valid_d    = 1'b1;
      id_instr_d    = skid_instr_q;
      id_pc_d       = skid_pc_q;
      id_pc_plus4_d = skid_pc_q + 32'd4;
    end else begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      id_pc        <= 32'd0;
      id_pc_plus4  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      id_valid     <= id_valid_d;
      id_instr     <= id_instr_d;
      id_pc        <= id_pc_d;
      id_pc_plus4  <= id_pc_plus4_d;
    end
  end

  // NOTE: the skid payload is not reset; it is only read while skid_valid_q is set.
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

endmodule
